lc3b_mem_unit: RTL and testbench

//  MAR/MDR memory-interface stage of the LC-3b datapath. Sits downstream of the ADDR/BUS producers
//  (PC/address adder, register file, ALU, SHF) and upstream of the system bus. It latches addresses
//  and write data from BUS and runs a req/ack handshake to memory. It returns the ready flag R to the

---
 rtl/lc3b_pkg.sv | 27 ++
 rtl/lc3b_mem_unit_if.sv | 30 +++
 rtl/lc3b_mdr_fmt.sv | 25 ++
 rtl/lc3b_mem_unit.sv | 136 +++++++++++++
 tb/tb_lc3b_mem_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_pkg.sv
// Shared types and constants for the LC-3b MAR/MDR memory-interface stage.
//   mem_state_t   : access sequencer states (IDLE, REQ, DONE)
//   SIZE_*        : DATA_SIZE encodings (byte / word)
//   RW_*          : R_W encodings (read / write)
//   byte_enables(): memory byte-lane enables from access size and address bit 0
package lc3b_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Word accesses use both lanes; byte accesses pick the lane by address bit 0
  // (odd address = high byte on a little-endian 16-bit bus).
  function automatic logic [1:0] byte_enables(input logic size, input logic a0);
    if (size == SIZE_WORD) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/lc3b_mem_unit_if.sv
// System-bus request/acknowledge channel between the MAR/MDR stage and memory.
//   mem_req   : request, held until mem_ack
//   mem_we    : write qualifier, valid with mem_req
//   mem_addr  : even word address
//   mem_wdata : write data
//   mem_be    : byte enables {hi, lo}
//   mem_rdata : read data, valid with mem_ack
//   mem_ack   : one-cycle completion
// Modports: master = datapath side, slave = memory side.
interface lc3b_mem_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/lc3b_mdr_fmt.sv
// Byte-lane formatting for the MDR, purely combinational.
//   mdr, mar0, data_size -> mdr_out : word = MDR; byte = sign-extended lane chosen by MAR[0]
//   bus, data_size       -> wr_lane : word = BUS; byte = low byte replicated into both lanes
module lc3b_mdr_fmt
  import lc3b_pkg::*;
(
  input  logic [15:0] mdr,
  input  logic        mar0,
  input  logic        data_size,
  input  logic [15:0] bus,
  output logic [15:0] mdr_out,
  output logic [15:0] wr_lane
);

  logic [7:0] lane;

  // NOTE: every always_comb output is assigned on every path (here unconditionally);
  // an output left unassigned on some path would infer a latch.
  always_comb begin
    lane    = mar0 ? mdr[15:8] : mdr[7:0];
    mdr_out = (data_size == SIZE_WORD) ? mdr : {{8{lane[7]}}, lane};
    wr_lane = (data_size == SIZE_BYTE) ? {bus[7:0], bus[7:0]} : bus;
  end

endmodule

// File: rtl/lc3b_mem_unit.sv
// LC-3b MAR/MDR memory-interface stage.
// Latches address/data from BUS, runs a req/ack access on the system bus and
// returns the one-cycle ready pulse R to the control FSM.
// Ports:
//   CLK, RESET (synchronous, active-high)
//   BUS, LD_MAR, LD_MDR, MIO_EN, R_W, DATA_SIZE : datapath controls
//   MDR_OUT   : formatted MDR for GateMDR (combinational)
//   R         : access complete pulse
//   bus_err   : sticky timeout flag, cleared only by RESET
//   unaligned : unaligned word-access pulse (trap build only)
//   mem       : system-bus channel (master side)
// Parameters: TIMEOUT (REQ cycles before forced completion, 0 = never), CNT_W.
// Build option: define LC3B_UNALIGNED_TRAP_EN to trap word accesses at odd
// addresses instead of performing them at the even address.
module lc3b_mem_unit
  import lc3b_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [15:0]        BUS,
  input  logic               LD_MAR,
  input  logic               LD_MDR,
  input  logic               MIO_EN,
  input  logic               R_W,
  input  logic               DATA_SIZE,
  output logic [15:0]        MDR_OUT,
  output logic               R,
  output logic               bus_err,
  output logic               unaligned,
  lc3b_mem_unit_if.master    mem
);

  localparam bit              TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  mem_state_t       state;
  logic [15:0]      mar;
  logic [15:0]      mdr;
  logic [15:0]      rd_buf;
  logic [CNT_W-1:0] counter;
  logic [15:0]      wr_lane;
  logic             trap;

`ifdef LC3B_UNALIGNED_TRAP_EN
  assign trap = (DATA_SIZE == SIZE_WORD) && mar[0];
`else
  assign trap = 1'b0;
`endif

  lc3b_mdr_fmt u_fmt (
    .mdr      (mdr),
    .mar0     (mar[0]),
    .data_size(DATA_SIZE),
    .bus      (BUS),
    .mdr_out  (MDR_OUT),
    .wr_lane  (wr_lane)
  );

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: every register, including the data holding regs, is cleared by the
      // synchronous reset; there is no array here that would make that costly.
      state         <= IDLE;
      mar           <= '0;
      mdr           <= '0;
      rd_buf        <= '0;
      counter       <= '0;
      R             <= 1'b0;
      bus_err       <= 1'b0;
      unaligned     <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= '0;
    end else begin
      R         <= 1'b0;
      unaligned <= 1'b0;

      if (LD_MAR) mar <= BUS;

      // Memory-sourced MDR loads are only meaningful once read data is captured.
      if (LD_MDR) begin
        if (!MIO_EN)            mdr <= wr_lane;
        else if (state == DONE) mdr <= rd_buf;
      end

      case (state)
        IDLE: begin
          if (MIO_EN) begin
            if (trap) begin
              state     <= DONE;
              R         <= 1'b1;
              unaligned <= 1'b1;
            end else begin
              state         <= REQ;
              counter       <= '0;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= (R_W == RW_WRITE);
              mem.mem_addr  <= {mar[15:1], 1'b0};
              mem.mem_wdata <= mdr;
              mem.mem_be    <= byte_enables(DATA_SIZE, mar[0]);
            end
          end
        end
        REQ: begin
          // An ack on the last allowed cycle wins over the timeout.
          if (mem.mem_ack) begin
            state       <= DONE;
            R           <= 1'b1;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            if (mem.mem_we == RW_READ) rd_buf <= mem.mem_rdata;
          end else if (TO_EN && counter == CNT_LAST) begin
            state       <= DONE;
            R           <= 1'b1;
            bus_err     <= 1'b1;
            rd_buf      <= '0;
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3b_mem_unit.sv
// Self-checking bench for lc3b_mem_unit (TIMEOUT=4).
// Table of MDR formatting vectors plus hand-written access sequences:
// word read, byte write, timeout, reset mid-request, unaligned word access.
module tb_lc3b_mem_unit;
  import lc3b_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] BUS;
  logic        LD_MAR, LD_MDR, MIO_EN, R_W, DATA_SIZE;
  logic [15:0] MDR_OUT;
  logic        R, bus_err, unaligned;

  lc3b_mem_unit_if mem_if ();

  lc3b_mem_unit #(.TIMEOUT(4), .CNT_W(3)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BUS      (BUS),
    .LD_MAR   (LD_MAR),
    .LD_MDR   (LD_MDR),
    .MIO_EN   (MIO_EN),
    .R_W      (R_W),
    .DATA_SIZE(DATA_SIZE),
    .MDR_OUT  (MDR_OUT),
    .R        (R),
    .bus_err  (bus_err),
    .unaligned(unaligned),
    .mem      (mem_if)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards apply at the next edge and
  // outputs read afterwards reflect this edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    LD_MAR = 0; LD_MDR = 0; MIO_EN = 0;
    mem_if.mem_ack = 0;
  endtask

  task automatic load_mar(input logic [15:0] v);
    BUS = v; LD_MAR = 1; step(); LD_MAR = 0;
  endtask

  task automatic load_mdr(input logic [15:0] v, input logic size);
    BUS = v; DATA_SIZE = size; MIO_EN = 0; LD_MDR = 1; step(); LD_MDR = 0;
  endtask

  typedef struct {
    logic [15:0] mar;
    logic [15:0] bus;
    logic        ld_size;
    logic        rd_size;
    logic [15:0] exp_out;
  } fmt_vec_t;

  fmt_vec_t vecs[8];
  int       req_cycles;
  int       r_count;

  initial begin
    vecs[0] = '{16'h0001, 16'h80FF, SIZE_WORD, SIZE_BYTE, 16'hFF80};
    vecs[1] = '{16'h0000, 16'h80FF, SIZE_WORD, SIZE_BYTE, 16'hFFFF};
    vecs[2] = '{16'h0000, 16'h80FF, SIZE_WORD, SIZE_WORD, 16'h80FF};
    vecs[3] = '{16'h0001, 16'h1234, SIZE_WORD, SIZE_BYTE, 16'h0012};
    vecs[4] = '{16'h0000, 16'h1234, SIZE_WORD, SIZE_BYTE, 16'h0034};
    vecs[5] = '{16'h0000, 16'h00A5, SIZE_BYTE, SIZE_WORD, 16'hA5A5};
    vecs[6] = '{16'h0003, 16'h007F, SIZE_BYTE, SIZE_BYTE, 16'h007F};
    vecs[7] = '{16'h0002, 16'h0080, SIZE_BYTE, SIZE_BYTE, 16'hFF80};

    BUS = '0; R_W = RW_READ; DATA_SIZE = SIZE_WORD; mem_if.mem_rdata = '0;
    idle_inputs();
    RESET = 1; step(); step(); RESET = 0;

    // Reset state
    check("rst_R", 16'(R), 16'h0);
    check("rst_bus_err", 16'(bus_err), 16'h0);
    check("rst_unaligned", 16'(unaligned), 16'h0);
    check("rst_mem_req", 16'(mem_if.mem_req), 16'h0);
    check("rst_mem_we", 16'(mem_if.mem_we), 16'h0);
    check("rst_mem_be", 16'(mem_if.mem_be), 16'h0);
    check("rst_mem_addr", mem_if.mem_addr, 16'h0);
    check("rst_mem_wdata", mem_if.mem_wdata, 16'h0);
    check("rst_mdr_out", MDR_OUT, 16'h0);

    // MDR formatting table
    for (int i = 0; i < 8; i++) begin
      load_mar(vecs[i].mar);
      load_mdr(vecs[i].bus, vecs[i].ld_size);
      DATA_SIZE = vecs[i].rd_size;
      #1;
      check($sformatf("fmt[%0d]", i), MDR_OUT, vecs[i].exp_out);
    end

    // Word read, ack on the third REQ cycle
    load_mar(16'h3000);
    load_mdr(16'h1357, SIZE_WORD);
    R_W = RW_READ; DATA_SIZE = SIZE_WORD; MIO_EN = 1;
    step(); MIO_EN = 0;
    check("rd_req", 16'(mem_if.mem_req), 16'h1);
    check("rd_we", 16'(mem_if.mem_we), 16'h0);
    check("rd_addr", mem_if.mem_addr, 16'h3000);
    check("rd_be", 16'(mem_if.mem_be), 16'h3);
    // Memory-sourced MDR load in REQ must not change MDR
    LD_MDR = 1; MIO_EN = 1;
    step(); LD_MDR = 0; MIO_EN = 0;
    check("rd_req_held", 16'(mem_if.mem_req), 16'h1);
    check("rd_mdr_in_req", MDR_OUT, 16'h1357);
    step();
    check("rd_no_early_R", 16'(R), 16'h0);
    mem_if.mem_ack = 1; mem_if.mem_rdata = 16'hBEEF;
    step(); mem_if.mem_ack = 0; mem_if.mem_rdata = 16'h0;
    check("rd_R", 16'(R), 16'h1);
    check("rd_req_drop", 16'(mem_if.mem_req), 16'h0);
    check("rd_no_err", 16'(bus_err), 16'h0);
    LD_MDR = 1; MIO_EN = 1;
    step(); LD_MDR = 0; MIO_EN = 0;
    check("rd_R_single", 16'(R), 16'h0);
    check("rd_mdr", MDR_OUT, 16'hBEEF);
    step();
    check("rd_no_restart", 16'(mem_if.mem_req), 16'h0);

    // Byte write at odd address
    load_mar(16'h4001);
    load_mdr(16'h00A5, SIZE_BYTE);
    R_W = RW_WRITE; DATA_SIZE = SIZE_BYTE; MIO_EN = 1;
    step(); MIO_EN = 0;
    check("wr_req", 16'(mem_if.mem_req), 16'h1);
    check("wr_we", 16'(mem_if.mem_we), 16'h1);
    check("wr_be", 16'(mem_if.mem_be), 16'h2);
    check("wr_wdata", mem_if.mem_wdata, 16'hA5A5);
    check("wr_addr", mem_if.mem_addr, 16'h4000);
    // MAR/MDR changes during REQ leave latched values alone
    load_mar(16'hFFFF);
    load_mdr(16'h1111, SIZE_WORD);
    check("wr_addr_hold", mem_if.mem_addr, 16'h4000);
    check("wr_wdata_hold", mem_if.mem_wdata, 16'hA5A5);
    mem_if.mem_ack = 1; mem_if.mem_rdata = 16'hDEAD;
    step(); mem_if.mem_ack = 0;
    check("wr_R", 16'(R), 16'h1);
    check("wr_we_drop", 16'(mem_if.mem_we), 16'h0);
    DATA_SIZE = SIZE_WORD; LD_MDR = 1; MIO_EN = 1;
    step(); LD_MDR = 0; MIO_EN = 0;
    check("wr_rdbuf_kept", MDR_OUT, 16'hBEEF);

    // Timeout: no ack
    load_mar(16'h5000);
    R_W = RW_READ; DATA_SIZE = SIZE_WORD; MIO_EN = 1;
    step(); MIO_EN = 0;
    req_cycles = 0;
    for (int i = 0; i < 10 && !R; i++) begin
      if (mem_if.mem_req) req_cycles++;
      step();
    end
    check("to_req_cycles", 16'(req_cycles), 16'd4);
    check("to_R", 16'(R), 16'h1);
    check("to_req_low", 16'(mem_if.mem_req), 16'h0);
    check("to_bus_err", 16'(bus_err), 16'h1);
    LD_MDR = 1; MIO_EN = 1;
    step(); LD_MDR = 0; MIO_EN = 0;
    check("to_rdbuf_zero", MDR_OUT, 16'h0);
    // Sticky across a later good access
    MIO_EN = 1; step(); MIO_EN = 0;
    mem_if.mem_ack = 1; mem_if.mem_rdata = 16'h0042;
    step(); mem_if.mem_ack = 0;
    check("to_ok_R", 16'(R), 16'h1);
    check("to_err_sticky", 16'(bus_err), 16'h1);
    step();

    // Reset mid-REQ, then a stray ack
    load_mar(16'h6001);
    load_mdr(16'h7777, SIZE_WORD);
    MIO_EN = 1; step(); MIO_EN = 0;
    check("rr_req", 16'(mem_if.mem_req), 16'h1);
    RESET = 1; step(); RESET = 0;
    check("rr_req_drop", 16'(mem_if.mem_req), 16'h0);
    check("rr_err_clr", 16'(bus_err), 16'h0);
    mem_if.mem_ack = 1; mem_if.mem_rdata = 16'h9999;
    step(); mem_if.mem_ack = 0;
    r_count = 0;
    for (int i = 0; i < 3; i++) begin
      if (R) r_count++;
      step();
    end
    check("rr_no_R", 16'(r_count), 16'h0);
    DATA_SIZE = SIZE_WORD; #1;
    check("rr_mdr_zero", MDR_OUT, 16'h0);
    // MAR cleared: a byte access without LD_MAR goes to address 0, low lane.
    // Ack in the first REQ cycle gives the minimum latency R two cycles after MIO_EN.
    DATA_SIZE = SIZE_BYTE; R_W = RW_READ; MIO_EN = 1;
    step(); MIO_EN = 0;
    check("rr_mar_zero", mem_if.mem_addr, 16'h0);
    check("rr_be_lo", 16'(mem_if.mem_be), 16'h1);
    mem_if.mem_ack = 1; mem_if.mem_rdata = 16'h0055;
    step(); mem_if.mem_ack = 0;
    check("min_lat_R", 16'(R), 16'h1);
    step();

    // Word access at odd address
    load_mar(16'h2001);
    DATA_SIZE = SIZE_WORD; R_W = RW_READ; MIO_EN = 1;
    step(); MIO_EN = 0;
`ifdef LC3B_UNALIGNED_TRAP_EN
    check("ua_no_req", 16'(mem_if.mem_req), 16'h0);
    check("ua_R", 16'(R), 16'h1);
    check("ua_flag", 16'(unaligned), 16'h1);
    step();
    check("ua_pulse", 16'(unaligned), 16'h0);
`else
    check("ua_req", 16'(mem_if.mem_req), 16'h1);
    check("ua_addr_even", mem_if.mem_addr, 16'h2000);
    check("ua_be", 16'(mem_if.mem_be), 16'h3);
    check("ua_flag_tied", 16'(unaligned), 16'h0);
    mem_if.mem_ack = 1; step(); mem_if.mem_ack = 0;
    check("ua_R", 16'(R), 16'h1);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
